fifo_burst_reader: RTL

Read-side consumer of the ADC sample dual-clock FIFO (64-bit words, normal, non-show-ahead read mode). Runs in the FIFO read clock domain. Issues rdreq only when rdempty is low and local buffer space exists. Re-emits samples on a valid/ready stream framed into fixed-length bursts (sop/eop) for the downstream packetiser. Enable/stop control always ends on a burst boundary.

---
 rtl/fifo_burst_reader_if.sv | 20 ++
 rtl/fifo_burst_reader.sv | 70 +++++++
 2 files changed

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: FIFO read port plus framed valid/ready output stream
// master = burst reader (drives rd_req and the stream), slave = FIFO/downstream side
interface fifo_burst_reader_if #(parameter int DATA_WIDTH = 64);
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_empty;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sop;
  logic                  out_eop;
  modport master (
    output rd_req, out_data, out_valid, out_sop, out_eop,
    input  rd_data, rd_empty, out_ready
  );
  modport slave (
    input  rd_req, out_data, out_valid, out_sop, out_eop,
    output rd_data, rd_empty, out_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a non-show-ahead FIFO into a sop/eop framed valid/ready stream
// ports: clk, clear (sync reset), enable (run level), bus (FIFO read + stream),
//        busy (active or buffered data), burst_count (completed bursts, wraps)
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 enable,
  fifo_burst_reader_if.master  bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] burst_count
);
  localparam int IW = $clog2(BURST_LEN);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] mem [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            occ;
  logic                  inflight, req_allowed, xfer, last;
  logic [IW-1:0]         req_idx, out_idx;
  always_ff @(posedge clk) state <= clear ? IDLE : state_nx;
  // FINISH keeps requesting until the current burst is fully requested, then waits for delivery
  always_comb begin
    state_nx = state == IDLE ? (enable ? RUN : IDLE) :
               state == RUN  ? (enable ? RUN : FINISH) :
               enable ? RUN :
               (req_idx == '0 && !inflight && occ == '0) ? IDLE : FINISH;
  end
  // space check counts the in-flight word so the 4-entry buffer can never overflow
  always_comb begin
    req_allowed   = state == RUN || (state == FINISH && req_idx != '0);
    bus.rd_req    = req_allowed && !bus.rd_empty && (occ + 3'(inflight) < 3'd4);
    busy          = state != IDLE || occ != '0;
    last          = out_idx == IW'(BURST_LEN - 1);
    bus.out_valid = occ != '0;
    bus.out_data  = mem[rd_ptr];
    bus.out_sop   = occ != '0 && out_idx == '0;
    bus.out_eop   = occ != '0 && last;
    xfer          = occ != '0 && bus.out_ready;
  end
  // the FIFO word lands the cycle after rd_req; clearing inflight drops a word still returning
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      inflight    <= 1'b0;
      req_idx     <= '0;
      out_idx     <= '0;
      burst_count <= '0;
    end else begin
      inflight <= bus.rd_req;
      if (inflight) begin
        mem[wr_ptr] <= bus.rd_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (xfer) begin
        rd_ptr  <= rd_ptr + 2'd1;
        out_idx <= last ? '0 : out_idx + IW'(1);
      end
      if (xfer && last) burst_count <= burst_count + CNT_WIDTH'(1);
      if (bus.rd_req) req_idx <= req_idx == IW'(BURST_LEN - 1) ? '0 : req_idx + IW'(1);
      occ <= occ + 3'(inflight) - 3'(xfer);
    end
  end
endmodule
